// File: rtl/order_pkt_pkg.sv
// Shared types, constants and frame helpers for the order packetizer.
package order_pkt_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;
   localparam int         FRAME_LEN   = 7;
   localparam int         ENTRY_W     = 40;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef logic [2:0] byte_idx_t;

   localparam byte_idx_t LAST_IDX = 3'd6;

   // Frame held as bytes; element 0 is the first byte on the wire.
   typedef logic [FRAME_LEN-1:0][7:0] frame_t;

   // XOR of the five payload bytes (msg_type, price hi/lo, size hi/lo).
   function automatic logic [7:0] frame_checksum(input logic [7:0]  msg_type,
                                                 input logic [15:0] price,
                                                 input logic [15:0] size);
      return msg_type ^ price[15:8] ^ price[7:0] ^ size[15:8] ^ size[7:0];
   endfunction

   // Expand a queued {msg_type, price, size} entry into the full wire frame.
   function automatic frame_t build_frame(input logic [7:0]         sof,
                                          input logic [ENTRY_W-1:0] entry);
      frame_t f;
      f[0] = sof;
      f[1] = entry[39:32];
      f[2] = entry[31:24];
      f[3] = entry[23:16];
      f[4] = entry[15:8];
      f[5] = entry[7:0];
      f[6] = frame_checksum(entry[39:32], entry[31:16], entry[15:0]);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. Occupancy is tracked by a counter so that
// full/empty never depend on pointer equality alone. A push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 40,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (level_r == LW'(DEPTH));
   assign empty_s   = (level_r == LW'(0));
   assign pop_ok_s  = pop && !empty_s;
   assign push_ok_s = push && (!full_s || pop_ok_s);

   assign rdata = mem_r[rd_ptr_r];
   assign full  = full_s;
   assign empty = empty_s;
   assign level = level_r;

   // Storage write; the slot being popped may be overwritten in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally modulo DEPTH; occupancy counter drives full/empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= LW'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/order_packetizer.sv
// Buffers trading decisions and serialises each one as a 7-byte frame
// (SOF, msg_type, price, size, checksum) on a byte-wide valid/ready stream.
// Decisions arriving with the FIFO full and no simultaneous pop are dropped
// and counted in a saturating counter.
module order_packetizer
   import order_pkt_pkg::*;
#(
   parameter  int         DEPTH    = 4,
   parameter  logic [7:0] SOF_BYTE = SOF_DEFAULT,
   parameter  int         CNT_W    = 16,
   localparam int         LW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_msg_type,
   input  logic [15:0]      in_price,
   input  logic [15:0]      in_size,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [7:0]       out_byte,
   output logic             busy,
   output logic [LW-1:0]    fifo_level,
   output logic [CNT_W-1:0] drop_count
);

   state_t             state_r;
   state_t             state_nxt_s;
   byte_idx_t          idx_r;
   byte_idx_t          idx_nxt_s;
   byte_idx_t          idx_inc_s;
   frame_t             frame_r;
   frame_t             frame_nxt_s;
   logic               out_valid_r;
   logic               out_valid_nxt_s;
   logic [7:0]         out_byte_r;
   logic [7:0]         out_byte_nxt_s;
   logic [CNT_W-1:0]   drop_count_r;
   logic               pop_s;
   logic               push_s;
   logic               full_s;
   logic               empty_s;
   logic [LW-1:0]      level_s;
   logic [ENTRY_W-1:0] head_s;

   // A write into a full FIFO is still legal when the head leaves this cycle.
   assign push_s    = in_valid && (!full_s || pop_s);
   assign idx_inc_s = idx_r + 3'd1;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata ({in_msg_type, in_price, in_size}),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level_s)
   );

   assign out_valid  = out_valid_r;
   assign out_byte   = out_byte_r;
   assign fifo_level = level_s;
   assign drop_count = drop_count_r;
   assign busy       = (state_r == SEND) || (level_s != LW'(0));

   // Next-state logic: load from FIFO, step through bytes, reload back-to-back.
   always_comb begin
      state_nxt_s     = state_r;
      idx_nxt_s       = idx_r;
      frame_nxt_s     = frame_r;
      out_valid_nxt_s = out_valid_r;
      out_byte_nxt_s  = out_byte_r;
      pop_s           = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s           = 1'b1;
               frame_nxt_s     = build_frame(SOF_BYTE, head_s);
               idx_nxt_s       = 3'd0;
               state_nxt_s     = SEND;
               out_valid_nxt_s = 1'b1;
               out_byte_nxt_s  = SOF_BYTE;
            end else begin
               out_valid_nxt_s = 1'b0;
               out_byte_nxt_s  = 8'h00;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx_r != LAST_IDX) begin
                  idx_nxt_s      = idx_inc_s;
                  out_byte_nxt_s = frame_r[idx_inc_s];
               end else if (!empty_s) begin
                  pop_s           = 1'b1;
                  frame_nxt_s     = build_frame(SOF_BYTE, head_s);
                  idx_nxt_s       = 3'd0;
                  out_valid_nxt_s = 1'b1;
                  out_byte_nxt_s  = SOF_BYTE;
               end else begin
                  state_nxt_s     = IDLE;
                  idx_nxt_s       = 3'd0;
                  out_valid_nxt_s = 1'b0;
                  out_byte_nxt_s  = 8'h00;
               end
            end else begin
               idx_nxt_s      = idx_r;
               out_byte_nxt_s = out_byte_r;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            idx_nxt_s       = 3'd0;
            out_valid_nxt_s = 1'b0;
            out_byte_nxt_s  = 8'h00;
         end
      endcase
   end

   // State, frame and registered output stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= 3'd0;
         frame_r     <= '0;
         out_valid_r <= 1'b0;
         out_byte_r  <= 8'h00;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         frame_r     <= frame_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_byte_r  <= out_byte_nxt_s;
      end
   end

   // Saturating count of decisions that found no room in the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count_r <= '0;
      end else if (in_valid && !push_s && (drop_count_r != '1)) begin
         drop_count_r <= drop_count_r + CNT_W'(1);
      end else begin
         drop_count_r <= drop_count_r;
      end
   end

endmodule

// File: tb/tb_order_packetizer.sv
// Directed bench for order_packetizer with a byte scoreboard.
module tb_order_packetizer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_msg_type;
   logic [15:0] in_price;
   logic [15:0] in_size;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        busy;
   logic [2:0]  fifo_level;
   logic [15:0] drop_count;

   int          tests_run = 0;
   int          fails     = 0;
   logic [7:0]  exp_q[$];
   logic        prev_stall;
   logic [7:0]  prev_byte;

   order_packetizer #(
      .DEPTH    (4),
      .SOF_BYTE (8'hA5),
      .CNT_W    (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_msg_type (in_msg_type),
      .in_price    (in_price),
      .in_size     (in_size),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_byte    (out_byte),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle decision strobe; when the bench expects acceptance the frame is queued.
   task automatic decide(input logic [7:0] m, input logic [15:0] p, input logic [15:0] s,
                         input bit accept);
      in_valid    = 1'b1;
      in_msg_type = m;
      in_price    = p;
      in_size     = s;
      if (accept) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(m);
         exp_q.push_back(p[15:8]);
         exp_q.push_back(p[7:0]);
         exp_q.push_back(s[15:8]);
         exp_q.push_back(s[7:0]);
         exp_q.push_back(m ^ p[15:8] ^ p[7:0] ^ s[15:8] ^ s[7:0]);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", 32'(n < budget), 32'd1);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   // Scoreboard monitor: a transfer happens at the next rising edge when valid&&ready.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(out_byte), 32'(prev_byte));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 32'(out_byte), 32'hFFFF_FFFF);
            end else begin
               check("byte", 32'(out_byte), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_byte  = out_byte;
      end
   end

   initial begin
      logic [3:0] pat;
      int         n;
      pat         = 4'b1001;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_msg_type = 8'h00;
      in_price    = 16'h0000;
      in_size     = 16'h0000;
      out_ready   = 1'b1;
      prev_stall  = 1'b0;
      prev_byte   = 8'h00;
      repeat (2) tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_byte", 32'(out_byte), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      rst = 1'b0;
      tick();

      // 1: single decision, latency and frame content
      decide(8'h42, 16'h1234, 16'h0010, 1'b1);
      check("lat_n1_valid", 32'(out_valid), 32'd0);
      check("lat_n1_level", 32'(fifo_level), 32'd1);
      check("lat_n1_busy", 32'(busy), 32'd1);
      tick();
      check("lat_n2_valid", 32'(out_valid), 32'd1);
      check("lat_n2_sof", 32'(out_byte), 32'hA5);
      check("lat_n2_level", 32'(fifo_level), 32'd0);
      drain(20);

      // 2: backpressure with ready pattern 1,0,0,1,...
      decide(8'h42, 16'h1234, 16'h0010, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         out_ready = pat[n % 4];
         tick();
         n++;
      end
      out_ready = 1'b1;
      check("bp_timeout", 32'(n < 60), 32'd1);
      drain(10);

      // 3: back-to-back frames, 14 contiguous valid bytes
      decide(8'h01, 16'hABCD, 16'h0F0F, 1'b1);
      decide(8'h02, 16'h5566, 16'h7788, 1'b1);
      for (int i = 0; i < 14; i++) begin
         check("b2b_contig", 32'(out_valid), 32'd1);
         tick();
      end
      check("b2b_end_valid", 32'(out_valid), 32'd0);
      drain(10);

      // 4: overflow with ready held low
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         decide(8'h10 + 8'(i), 16'h1000 + 16'(i), 16'h0200 + 16'(i), i < 5);
      end
      check("ovf_drop", 32'(drop_count), 32'd1);
      check("ovf_level", 32'(fifo_level), 32'd4);
      check("ovf_sof", 32'(out_byte), 32'hA5);
      out_ready = 1'b1;
      drain(60);

      // 5: full FIFO plus write coincident with reload pop
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         decide(8'h20 + 8'(i), 16'h2000 + 16'(i), 16'h0300 + 16'(i), 1'b1);
      end
      check("full_level", 32'(fifo_level), 32'd4);
      out_ready = 1'b1;
      repeat (6) tick();
      decide(8'h2F, 16'hBEEF, 16'hCAFE, 1'b1);
      check("full_pop_level", 32'(fifo_level), 32'd4);
      check("full_pop_drop", 32'(drop_count), 32'd1);
      drain(60);

      // 6: reset mid-frame, then a fresh frame
      decide(8'h33, 16'h4455, 16'h6677, 1'b1);
      tick();
      repeat (3) tick();
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_drop", 32'(drop_count), 32'd0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      decide(8'h99, 16'h0102, 16'h0304, 1'b1);
      tick();
      check("post_rst_sof", 32'(out_byte), 32'hA5);
      drain(20);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
